// File: rtl/fifo_stream_pkg.sv
// Shared types for the read-domain stream path: reader FSM states and the
// {last,data} word held in the output buffer.
package fifo_stream_pkg;

  localparam int STREAM_DW = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    TRICKLE = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic                 last;
    logic [STREAM_DW-1:0] data;
  } stream_word_t;

  function automatic stream_word_t make_word(input logic last, input logic [STREAM_DW-1:0] data);
    stream_word_t w;
    w.last = last;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer: entry0 is always the head, so the stream outputs
// come straight from flops and stay stable while the consumer stalls.
module skid_buf2
  import fifo_stream_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  stream_word_t push_word,
  input  logic         pop,
  output stream_word_t head,
  output logic [1:0]   occ
);

  stream_word_t entry0;
  stream_word_t entry1;
  logic [1:0]   occ_q;
  logic         do_pop;

  assign do_pop = pop & (occ_q != 2'd0);

  // occupancy and entry shifting; a push when full cannot happen because
  // the reader gates its pops on occ<2
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      occ_q  <= 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            entry0 <= push_word;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && do_pop) begin
            entry0 <= push_word;
          end else if (push) begin
            entry1 <= push_word;
            occ_q  <= 2'd2;
          end else if (do_pop) begin
            occ_q  <= 2'd0;
          end
        end
        2'd2: begin
          if (do_pop) begin
            entry0 <= entry1;
            if (push) begin
              entry1 <= push_word;
            end else begin
              occ_q  <= 2'd1;
            end
          end
        end
        default: begin
          occ_q <= 2'd0;
        end
      endcase
    end
  end

  assign head = entry0;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream framed as
// BURST_LEN-beat packets, releasing stragglers as 1-beat packets after TIMEOUT.
module fifo_burst_reader
  import fifo_stream_pkg::*;
#(
  parameter int DW        = 10,
  parameter int BURST_LEN = 4,
  parameter int AE_LEVEL  = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic          r_clk,
  input  logic          r_rst,
  input  logic [DW-1:0] fifo_dat,
  input  logic          fifo_empty,
  input  logic          fifo_almost_empty,
  output logic          fifo_r_en,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic [15:0]   pkt_cnt
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  if (BURST_LEN < 1 || BURST_LEN > AE_LEVEL + 1) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must be in 1..AE_LEVEL+1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT must be >= 1");
  end
  if (DW != STREAM_DW) begin : g_bad_dw
    $error("fifo_burst_reader: DW must match fifo_stream_pkg::STREAM_DW");
  end

  rd_state_e     state;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] timer;
  logic [1:0]    occ;
  logic          pop;
  logic          last_tag;
  stream_word_t  push_word;
  stream_word_t  head;

  // Only registered terms plus fifo_empty; m_ready never reaches the FIFO.
  assign pop       = ~r_rst & (state != IDLE) & ~fifo_empty & (occ != 2'd2);
  assign fifo_r_en = pop;
  assign push_word = make_word(last_tag, fifo_dat);

  // packet framing tag for the word being popped this cycle
  always_comb begin
    if (state == TRICKLE) begin
      last_tag = 1'b1;
    end else if (state == BURST) begin
      last_tag = (beat_cnt == LAST_BEAT);
    end else begin
      last_tag = 1'b0;
    end
  end

  // reader FSM with beat and idle-timeout counters
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_almost_empty) begin
            state    <= BURST;
            beat_cnt <= '0;
            timer    <= '0;
          end else if (!fifo_empty) begin
            if (timer == TIMER_END) begin
              state <= TRICKLE;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            timer <= '0;
          end
        end
        BURST: begin
          if (pop) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        TRICKLE: begin
          // leave so a refilled FIFO gets re-framed as full bursts
          if (fifo_empty || (!fifo_almost_empty && !pop)) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
          timer    <= '0;
        end
      endcase
    end
  end

  // count packets as their last beat is accepted downstream
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      pkt_cnt <= 16'd0;
    end else if (m_valid && m_ready && m_last) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end else begin
      pkt_cnt <= pkt_cnt;
    end
  end

  skid_buf2 u_buf (
    .clk       (r_clk),
    .rst       (r_rst),
    .push      (pop),
    .push_word (push_word),
    .pop       (m_ready),
    .head      (head),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head.data;
  assign m_last  = head.last;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue stands in for the FWFT FIFO, and a
// beat-level reference model predicts pops, stream beats and packet counts.
module tb_fifo_burst_reader;

  localparam int DW        = 10;
  localparam int BURST_LEN = 4;
  localparam int AE_LEVEL  = 4;
  localparam int TIMEOUT   = 64;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic [DW-1:0] fifo_dat;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic [15:0]   pkt_cnt;

  always #5 r_clk = ~r_clk;

  fifo_burst_reader #(
    .DW(DW), .BURST_LEN(BURST_LEN), .AE_LEVEL(AE_LEVEL), .TIMEOUT(TIMEOUT)
  ) dut (
    .r_clk             (r_clk),
    .r_rst             (r_rst),
    .fifo_dat          (fifo_dat),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_r_en         (fifo_r_en),
    .m_valid           (m_valid),
    .m_data            (m_data),
    .m_last            (m_last),
    .m_ready           (m_ready),
    .pkt_cnt           (pkt_cnt)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   mq[$];
  logic [DW:0]   got[$];
  int            burst_left;
  int            idle_wait;
  bit            trickling;
  logic [15:0]   mpkt;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty        = (fifo_q.size() == 0);
    fifo_almost_empty = (fifo_q.size() <= AE_LEVEL);
    fifo_dat          = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic wr(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    upd_fifo();
  endtask

  function automatic bit exp_ren();
    return !r_rst && (burst_left > 0 || trickling) && fifo_q.size() > 0 && mq.size() < 2;
  endfunction

  task automatic check_outputs();
    chk("fifo_r_en", fifo_r_en, exp_ren());
    chk("m_valid", m_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_data", m_data, mq[0][DW-1:0]);
      chk("m_last", m_last, mq[0][DW]);
    end
    chk("pkt_cnt", pkt_cnt, mpkt);
  endtask

  // advance the reference by one clock edge, using the pre-edge environment
  task automatic model_edge();
    int n;
    bit p;
    logic lt;
    n = fifo_q.size();
    p = exp_ren();
    if (r_rst) begin
      mq.delete();
      burst_left = 0;
      trickling  = 1'b0;
      idle_wait  = 0;
      mpkt       = 16'd0;
    end else begin
      if (mq.size() != 0 && m_ready) begin
        if (mq[0][DW]) mpkt = mpkt + 16'd1;
        void'(mq.pop_front());
      end
      if (p) begin
        lt = trickling || (burst_left == 1);
        mq.push_back({lt, fifo_q[0]});
      end
      if (burst_left > 0) begin
        if (p) burst_left--;
      end else if (trickling) begin
        if (n == 0 || (n > AE_LEVEL && !p)) trickling = 1'b0;
      end else if (n > AE_LEVEL) begin
        burst_left = BURST_LEN;
        idle_wait  = 0;
      end else if (n > 0) begin
        if (idle_wait == TIMEOUT - 1) begin
          trickling = 1'b1;
          idle_wait = 0;
        end else begin
          idle_wait++;
        end
      end else begin
        idle_wait = 0;
      end
    end
  endtask

  // one clock: compare before the edge, let the FIFO follow the DUT's pop after it
  task automatic cycle();
    bit pop_now;
    #1;
    check_outputs();
    pop_now = fifo_r_en && !fifo_empty;
    if (m_valid && m_ready && !r_rst) got.push_back({m_last, m_data});
    model_edge();
    @(posedge r_clk);
    #1;
    if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
    @(negedge r_clk);
  endtask

  task automatic drain(input bit toggle, input int limit);
    int i;
    i = 0;
    while ((fifo_q.size() != 0 || mq.size() != 0 || m_valid) && i < limit) begin
      if (toggle) m_ready = ~m_ready;
      cycle();
      i++;
    end
    chk("drain_timeout", fifo_q.size() + mq.size(), 0);
    m_ready = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    burst_left = 0; idle_wait = 0; trickling = 1'b0; mpkt = 16'd0;
    r_rst = 1'b1; m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) fifo_q.push_back(DW'(i));
    upd_fifo();
    @(posedge r_clk);
    @(negedge r_clk);

    // 1: reset held with a pre-filled FIFO
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_r_en", fifo_r_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_pkt", pkt_cnt, 0);
    end
    fifo_q.delete();
    upd_fifo();
    r_rst = 1'b0;
    m_ready = 1'b1;

    // 2: eight words; the 4 left after the burst sit at almost-empty and trickle
    got.delete();
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    drain(1'b0, 400);
    chk("t2_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) begin
      chk("t2_data", got[i][DW-1:0], i + 1);
      chk("t2_last", got[i][DW], (i < 4) ? (i == 3) : 1);
    end
    chk("t2_pkt", pkt_cnt, 5);
    chk("t2_model_pkt", mpkt, 5);

    // 3: three words wait out the timeout, then leave as 1-beat packets
    got.delete();
    for (int i = 0; i < 3; i++) wr(DW'(17 + i));
    for (int i = 0; i < 60; i++) cycle();
    chk("t3_quiet_valid", m_valid, 0);
    chk("t3_quiet_got", got.size(), 0);
    drain(1'b0, 400);
    chk("t3_count", got.size(), 3);
    for (int i = 0; i < got.size(); i++) begin
      chk("t3_data", got[i][DW-1:0], 17 + i);
      chk("t3_last", got[i][DW], 1);
    end
    chk("t3_pkt", pkt_cnt, 8);

    // 4: stalled consumer stops popping after two words
    got.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i >= 4) begin
        chk("t4_stall_r_en", fifo_r_en, 0);
        chk("t4_hold_data", m_data, 1);
        chk("t4_hold_valid", m_valid, 1);
      end
    end
    chk("t4_fifo_left", fifo_q.size(), 6);
    m_ready = 1'b1;
    drain(1'b0, 400);
    chk("t4_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("t4_data", got[i][DW-1:0], i + 1);
    chk("t4_pkt", pkt_cnt, 13);

    // 5: alternating ready over 16 words
    got.delete();
    for (int i = 0; i < 16; i++) wr(DW'(32 + i));
    drain(1'b1, 600);
    chk("t5_count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) begin
      chk("t5_data", got[i][DW-1:0], 32 + i);
      chk("t5_last", got[i][DW], (i < 12) ? (i % 4 == 3) : 1);
    end

    // 6: reset after two accepted beats of a burst
    got.delete();
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    for (int i = 0; i < 50 && got.size() < 2; i++) cycle();
    chk("t6_reach_two", got.size(), 2);
    r_rst = 1'b1;
    cycle();
    chk("t6_valid", m_valid, 0);
    chk("t6_data", m_data, 0);
    chk("t6_last", m_last, 0);
    chk("t6_pkt", pkt_cnt, 0);
    r_rst = 1'b0;
    got.delete();
    drain(1'b0, 400);
    chk("t6_count", got.size(), 5);
    if (got.size() != 0) chk("t6_first", got[0][DW-1:0], 4);
    chk("t6_pkt_after", pkt_cnt, 2);

    // random traffic, backpressure and occasional resets
    for (int c = 0; c < 2500; c++) begin
      int nw;
      if ($urandom_range(0, 99) < 35 && fifo_q.size() < 900) begin
        nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++) wr(DW'($urandom_range(0, 1023)));
      end
      m_ready = ($urandom_range(0, 3) != 0);
      r_rst   = ($urandom_range(0, 499) == 0);
      cycle();
    end
    r_rst = 1'b0;
    m_ready = 1'b1;
    drain(1'b0, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
